avm_uart_responder: RTL and testbench
=====================================

Name: avm_uart_responder

Overview:
- Avalon-MM slave that implements the RS232-style register map polled by the SW host-side master: RX data, TX data and status.
- Two byte-stream ports connect it to the serial side: an RX byte stream is buffered toward the master, and bytes the master writes are buffered out on the TX stream.
- Serves as the synthesizable responder for the SW wrapper in system simulation and FPGA loopback builds.

Parameters:
- FIFO_DEPTH, 16: entries in each of the RX and TX FIFOs; power of 2, at least 2.
- WAIT_CYCLES, 1: cycles from access acceptance to the response cycle; at least 1.

Ports:
- avm_clk  in  1  clock
- avm_rst_n  in  1  synchronous, active-low reset
- avs_address  in  5  byte address: 0 = RX, 4 = TX, 8 = STATUS
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  32  write data; TX uses bits [7:0]
- avs_readdata  out  32  read data, valid when avs_waitrequest=0
- avs_waitrequest  out  1  0 only in the response cycle
- rx_valid  in  1  serial-side byte available
- rx_data  in  8  serial-side byte
- rx_ready  out  1  RX FIFO can accept a byte
- tx_valid  out  1  TX FIFO head is valid
- tx_data  out  8  TX FIFO head byte
- tx_ready  in  1  serial side consumes the byte

Behaviour:
- Reset (avm_rst_n=0 at a clock edge) clears FIFOs, sticky bits and FSM; also valid mid-access, where the pending access is dropped with no pop or push.
- Output values during and after reset: avs_waitrequest=1, avs_readdata=0, tx_valid=0, rx_ready=0 while in reset, then 1.
- FSM states:
  - IDLE: if avs_read or avs_write, latch address and command. Go to RESP if WAIT_CYCLES=1, else to WAIT.
  - WAIT: count WAIT_CYCLES-1 cycles, then go to RESP.
  - RESP: one cycle, then IDLE.
- Response timing: avs_waitrequest=0 only in RESP. Response appears WAIT_CYCLES cycles after acceptance.
- Back-to-back accesses: a request held high through RESP is re-accepted in the following IDLE cycle.
- avs_read and avs_write both high: treated as a read; the write is ignored.
- avs_readdata is registered on entry to RESP and is 0 in every other cycle:
  - RX (addr 0): {24'b0, RX head}; pops in the RESP cycle. If RX is empty, returns 0, no pop, and sets RX_UNDERFLOW.
  - STATUS (addr 8):
    - bit7 RX_OK = RX not empty
    - bit6 TX_OK = TX not full
    - bit8 RX_UNDERFLOW, sticky
    - bit9 TX_OVERFLOW, sticky
    - bit10 RX_DROP, sticky
    - all other bits 0
  - Any other address reads 0.
- Write to TX (addr 4): pushes writedata[7:0] in the RESP cycle. If TX is full, the byte is dropped and TX_OVERFLOW is set. Writes to other addresses are ignored but still complete.
- Sticky bits:
  - Cleared in the RESP cycle of a STATUS read.
  - A set event in that same cycle wins.
  - The STATUS readdata returned shows the pre-clear value.
- RX stream:
  - rx_ready = !rx_full, taken from registered state; it is 0 when full even if a pop occurs in the same cycle.
  - A byte is pushed on rx_valid && rx_ready.
  - rx_valid while full: byte discarded, RX_DROP set.
- TX stream: tx_valid = !tx_empty, tx_data = head. Pop on tx_valid && tx_ready.
- Simultaneous push and pop on one FIFO in the same cycle: both take effect and the count is unchanged; the full and empty flags stay correct.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit. The count saturates at FIFO_DEPTH.

Decomposition:
- Package avm_uart_pkg holds:
  - address constants RX_BASE=0, TX_BASE=4, STATUS_BASE=8
  - status bit indices TX_OK_BIT=6, RX_OK_BIT=7, RX_UNDERFLOW_BIT=8, TX_OVERFLOW_BIT=9, RX_DROP_BIT=10
  - the FSM state enum
- Sub-module: byte_sync_fifo, a parameterized depth, 8-bit synchronous FIFO with push, pop, full, empty and count; instantiated twice.

Test Plan:
- Reset then STATUS read (WAIT_CYCLES=1): waitrequest low exactly 1 cycle after acceptance; readdata=0x40 (TX_OK only).
- Push 0xA5 and 0x3C on RX, then poll STATUS: 0xC0. RX read returns 0xA5, then 0x3C. Next STATUS returns 0x40.
- Write 0x11, 0x22, 0x33 to TX with tx_ready=0: tx_valid=1, tx_data=0x11. Raise tx_ready: 0x11, 0x22, 0x33 in consecutive cycles, then tx_valid=0.
- Fill TX with 16 writes, then one more: the 17th is dropped; STATUS=0x200 (TX_OK=0), next STATUS=0x000. Drain one byte: next STATUS=0x40.
- RX read when empty: readdata=0, STATUS bit8 set. Push 17 RX bytes with the FIFO not drained: 17th dropped, rx_ready=0 after the 16th, STATUS shows bit10.
- Hold avs_read high continuously on STATUS with WAIT_CYCLES=3, and assert avm_rst_n=0 in a WAIT cycle: no response pulse; after release, responses arrive every 4 cycles.

Source files
------------

// File: rtl/avm_uart_responder_pkg.sv
// Shared constants and types for the Avalon-MM UART responder:
// register map, STATUS bit positions, FSM state type and a status packer.
package avm_uart_pkg;

    localparam int AVS_ADDR_W = 5;
    localparam int AVS_DATA_W = 32;

    // Byte addresses of the three registers
    localparam logic [AVS_ADDR_W-1:0] RX_BASE     = 5'd0;
    localparam logic [AVS_ADDR_W-1:0] TX_BASE     = 5'd4;
    localparam logic [AVS_ADDR_W-1:0] STATUS_BASE = 5'd8;

    // STATUS register bit positions
    localparam int TX_OK_BIT        = 6;
    localparam int RX_OK_BIT        = 7;
    localparam int RX_UNDERFLOW_BIT = 8;
    localparam int TX_OVERFLOW_BIT  = 9;
    localparam int RX_DROP_BIT      = 10;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } avm_state_e;

    // Assemble the STATUS word; every bit not named here reads as zero
    function automatic logic [AVS_DATA_W-1:0] pack_status(
        input logic rx_ok,
        input logic tx_ok,
        input logic rx_underflow,
        input logic tx_overflow,
        input logic rx_drop
    );
        logic [AVS_DATA_W-1:0] word;
        word                   = '0;
        word[RX_OK_BIT]        = rx_ok;
        word[TX_OK_BIT]        = tx_ok;
        word[RX_UNDERFLOW_BIT] = rx_underflow;
        word[TX_OVERFLOW_BIT]  = tx_overflow;
        word[RX_DROP_BIT]      = rx_drop;
        return word;
    endfunction

endpackage

// File: rtl/avm_uart_responder_if.sv
// Avalon-MM slave bus bundle used between the host-side master and the responder.
interface avm_uart_responder_if;
    import avm_uart_pkg::*;

    logic [AVS_ADDR_W-1:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [AVS_DATA_W-1:0] avs_writedata;
    logic [AVS_DATA_W-1:0] avs_readdata;
    logic                  avs_waitrequest;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata,
        input  avs_waitrequest
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata,
        output avs_waitrequest
    );
endinterface

// File: rtl/avm_uart_responder_byte_sync_fifo.sv
// 8-bit synchronous FIFO with wrap-bit pointers. Push while full and pop while
// empty are ignored, so callers may issue them unconditionally.
module byte_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic                     pop_i,
    output logic [7:0]               head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Same index with differing wrap bits means the write side lapped the read side
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance; push and pop in one cycle both move, leaving the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/avm_uart_responder.sv
// Avalon-MM slave exposing RX data, TX data and STATUS registers in front of
// two byte FIFOs that connect to the serial-side byte streams.
module avm_uart_responder
    import avm_uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                       avm_clk,
    input  logic                       avm_rst_n,
    avm_uart_responder_if.slave        avs,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       rx_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'((WAIT_CYCLES > 1) ? (WAIT_CYCLES - 2) : 0);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    // Sequencer state
    avm_state_e            state_q, state_d;
    logic [AVS_ADDR_W-1:0] addr_q, addr_d;
    logic                  is_read_q, is_read_d;
    logic                  is_write_q, is_write_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

    // Response registers
    logic [AVS_DATA_W-1:0] rdata_q, rdata_d;
    logic                  waitreq_q, waitreq_d;
    logic                  rx_hit_q, rx_hit_d;
    logic [2:0]            seen_q, seen_d;

    // Sticky error flags: [0] RX underflow, [1] TX overflow, [2] RX drop
    logic [2:0]            sticky_q, sticky_d;
    logic [2:0]            sticky_set;

    // FIFO side
    logic [7:0]            rx_head;
    logic                  rx_full, rx_empty, rx_push, rx_pop;
    logic [AW:0]           rx_count;
    logic                  tx_full, tx_empty, tx_push, tx_pop;
    logic [AW:0]           tx_count;

    logic                  accept;
    logic                  in_resp;
    logic [AVS_ADDR_W-1:0] cur_addr;
    logic                  cur_read;
    logic                  status_clr;
    logic                  wdata_unused;

    assign wdata_unused = ^avs.avs_writedata[AVS_DATA_W-1:8];

    byte_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i       (avm_clk),
        .rst_n_i     (avm_rst_n),
        .push_i      (rx_push),
        .push_data_i (rx_data),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .count_o     (rx_count)
    );

    byte_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i       (avm_clk),
        .rst_n_i     (avm_rst_n),
        .push_i      (tx_push),
        .push_data_i (avs.avs_writedata[7:0]),
        .pop_i       (tx_pop),
        .head_o      (tx_data),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (tx_count)
    );

    // Stream handshakes come from registered FIFO flags and are held off during reset
    assign rx_ready = avm_rst_n && !rx_full;
    assign tx_valid = avm_rst_n && !tx_empty;
    assign rx_push  = rx_valid && rx_ready;
    assign tx_pop   = tx_valid && tx_ready;

    assign accept  = (state_q == ST_IDLE) && (avs.avs_read || avs.avs_write);
    assign in_resp = (state_q == ST_RESP);

    // The response is captured on the edge entering RESP; when coming straight
    // from IDLE the command has not been latched yet, so look at the bus directly
    assign cur_addr = (state_q == ST_IDLE) ? avs.avs_address : addr_q;
    assign cur_read = (state_q == ST_IDLE) ? avs.avs_read    : is_read_q;

    // Next-state logic for the accept / wait / respond sequence
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        is_read_d  = is_read_q;
        is_write_d = is_write_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d     = avs.avs_address;
                    is_read_d  = avs.avs_read;
                    // A simultaneous read and write is served as a read only
                    is_write_d = avs.avs_write && !avs.avs_read;
                    wait_cnt_d = '0;
                    state_d    = (WAIT_CYCLES == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is formed on entry to RESP and is zero in every other cycle
    always_comb begin
        rdata_d   = '0;
        rx_hit_d  = 1'b0;
        seen_d    = '0;
        waitreq_d = (state_d != ST_RESP);
        if ((state_d == ST_RESP) && cur_read) begin
            if (cur_addr == RX_BASE) begin
                if (!rx_empty) begin
                    rdata_d  = {24'b0, rx_head};
                    rx_hit_d = 1'b1;
                end
            end else if (cur_addr == STATUS_BASE) begin
                rdata_d = pack_status(!rx_empty, !tx_full,
                                      sticky_q[0], sticky_q[1], sticky_q[2]);
                seen_d  = sticky_q;
            end
        end
    end

    // Side effects of the RESP cycle: RX pop, TX push and sticky updates
    always_comb begin
        rx_pop        = in_resp && is_read_q && (addr_q == RX_BASE) && rx_hit_q;
        tx_push       = in_resp && is_write_q && (addr_q == TX_BASE);
        status_clr    = in_resp && is_read_q && (addr_q == STATUS_BASE);
        sticky_set[0] = in_resp && is_read_q && (addr_q == RX_BASE) && !rx_hit_q;
        sticky_set[1] = tx_push && tx_full;
        sticky_set[2] = rx_valid && rx_full;
        // Only bits already reported to the host are cleared, so an event landing
        // between capture and clear is kept; a set in the clear cycle still wins
        sticky_d = (sticky_q & ~(status_clr ? seen_q : 3'b000)) | sticky_set;
    end

    // State and response registers with synchronous active-low reset
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            is_read_q  <= 1'b0;
            is_write_q <= 1'b0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            waitreq_q  <= 1'b1;
            rx_hit_q   <= 1'b0;
            seen_q     <= '0;
            sticky_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            is_read_q  <= is_read_d;
            is_write_q <= is_write_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            waitreq_q  <= waitreq_d;
            rx_hit_q   <= rx_hit_d;
            seen_q     <= seen_d;
            sticky_q   <= sticky_d;
        end
    end

    assign avs.avs_readdata    = rdata_q;
    assign avs.avs_waitrequest = waitreq_q;

    // FIFO occupancy never exceeds the depth and agrees with the full flag
    ap_rx_count: assert property (@(posedge avm_clk) disable iff (!avm_rst_n)
        (rx_count <= DEPTH_CNT) && (rx_full == (rx_count == DEPTH_CNT)));
    ap_tx_count: assert property (@(posedge avm_clk) disable iff (!avm_rst_n)
        (tx_count <= DEPTH_CNT) && (tx_full == (tx_count == DEPTH_CNT)));

endmodule

// File: tb/tb_avm_uart_responder.sv
// Bench for avm_uart_responder: directed scenarios plus a randomized mix,
// all checked against queue-based register/FIFO reference model.
module tb_avm_uart_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;

    avm_uart_responder_if bus1();
    avm_uart_responder_if bus2();

    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid2, rx_ready2, tx_valid2, tx_ready2;
    logic [7:0] rx_data2, tx_data2;

    avm_uart_responder #(.FIFO_DEPTH(16), .WAIT_CYCLES(1)) dut (
        .avm_clk   (clk),
        .avm_rst_n (rst_n),
        .avs       (bus1.slave),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
    );

    avm_uart_responder #(.FIFO_DEPTH(16), .WAIT_CYCLES(3)) dut_w3 (
        .avm_clk   (clk),
        .avm_rst_n (rst2_n),
        .avs       (bus2.slave),
        .rx_valid  (rx_valid2),
        .rx_data   (rx_data2),
        .rx_ready  (rx_ready2),
        .tx_valid  (tx_valid2),
        .tx_data   (tx_data2),
        .tx_ready  (tx_ready2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents and sticky flags
    logic [7:0] rx_m[$];
    logic [7:0] tx_m[$];
    logic       unf_m, ovf_m, drop_m;

    function automatic logic [31:0] model_status();
        logic [31:0] v;
        v      = 32'h0;
        v[7]   = (rx_m.size() != 0);
        v[6]   = (tx_m.size() < 16);
        v[8]   = unf_m;
        v[9]   = ovf_m;
        v[10]  = drop_m;
        unf_m  = 1'b0;
        ovf_m  = 1'b0;
        drop_m = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] model_rx_read();
        if (rx_m.size() != 0) return {24'h0, rx_m.pop_front()};
        unf_m = 1'b1;
        return 32'h0;
    endfunction

    function automatic void model_tx_write(input logic [7:0] d);
        if (tx_m.size() < 16) tx_m.push_back(d);
        else ovf_m = 1'b1;
    endfunction

    function automatic void model_rx_push(input logic [7:0] d);
        if (rx_m.size() < 16) rx_m.push_back(d);
        else drop_m = 1'b1;
    endfunction

    // One Avalon access on the WAIT_CYCLES=1 instance; returns to an IDLE slave
    task automatic access(input logic rd, input logic wr, input logic [4:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata, output int lat);
        bus1.avs_address   = addr;
        bus1.avs_read      = rd;
        bus1.avs_write     = wr;
        bus1.avs_writedata = wd;
        lat   = 0;
        rdata = 32'h0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus1.avs_waitrequest === 1'b0) begin
                lat   = n;
                rdata = bus1.avs_readdata;
                break;
            end
        end
        bus1.avs_read  = 1'b0;
        bus1.avs_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rx_push_raw(input logic [7:0] d, output logic rdy);
        rx_valid = 1'b1;
        rx_data  = d;
        rdy      = rx_ready;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic tx_step(output logic v, output logic [7:0] d);
        v        = tx_valid;
        d        = tx_data;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus1.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq got=%b exp=1", bus1.avs_waitrequest); end
        total++; if (bus1.avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", bus1.avs_readdata); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        rst_n = 1'b1;
        #1;
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL post_reset_rx_ready got=%b exp=1", rx_ready); end
        @(posedge clk); #1;
        access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat);
        ex = model_status();
        total++; if (lat !== 1) begin bad++; $display("FAIL reset_status_latency got=%0d exp=1", lat); end
        total++; if (rd !== ex) begin bad++; $display("FAIL reset_status got=%h exp=%h", rd, ex); end
        $display("reset: status=%h latency=%0d", rd, lat);
    endtask

    task automatic test_rx_stream();
        logic [31:0] rd, ex;
        logic [7:0]  d;
        logic        rdy;
        int lat;
        for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? 8'hA5 : 8'h3C;
            rx_push_raw(d, rdy);
            total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rx_ready_push%0d got=%b exp=1", i, rdy); end
            model_rx_push(d);
        end
        access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat); ex = model_status();
        total++; if (rd !== ex) begin bad++; $display("FAIL rx_status_two got=%h exp=%h", rd, ex); end
        for (int i = 0; i < 2; i++) begin
            access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat); ex = model_rx_read();
            total++; if (rd !== ex || lat !== 1) begin bad++; $display("FAIL rx_read%0d got=%h/%0d exp=%h/1", i, rd, lat, ex); end
            $display("rx read: data=%h", rd);
        end
        access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat); ex = model_status();
        total++; if (rd !== ex) begin bad++; $display("FAIL rx_status_empty got=%h exp=%h", rd, ex); end
        for (int k = 0; k < 4; k++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                rx_push_raw(d, rdy);
                model_rx_push(d);
            end
            for (int i = 0; i < n; i++) begin
                access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat); ex = model_rx_read();
                total++; if (rd !== ex) begin bad++; $display("FAIL rx_rand_read got=%h exp=%h", rd, ex); end
            end
        end
    endtask

    task automatic test_tx_stream();
        logic [31:0] rd;
        int lat;
        for (int i = 1; i <= 3; i++) begin
            access(1'b0, 1'b1, 5'd4, 32'(i * 8'h11), rd, lat);
            model_tx_write(8'(i * 8'h11));
            total++; if (lat !== 1) begin bad++; $display("FAIL tx_write_latency got=%0d exp=1", lat); end
        end
        @(posedge clk); #1;
        total++; if (tx_valid !== 1'b1 || tx_data !== tx_m[0]) begin bad++; $display("FAIL tx_hold got=%b/%h exp=1/%h", tx_valid, tx_data, tx_m[0]); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== tx_m[0]) begin bad++; $display("FAIL tx_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, tx_m[0]); end
            $display("tx drain: data=%h", tx_data);
            @(posedge clk); #1;
            void'(tx_m.pop_front());
        end
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] rd, ex;
        logic        v;
        logic [7:0]  d, wb;
        int lat;
        for (int i = 0; i < 17; i++) begin
            wb = 8'($urandom);
            access(1'b0, 1'b1, 5'd4, {24'($urandom), wb}, rd, lat);
            model_tx_write(wb);
        end
        for (int i = 0; i < 2; i++) begin
            access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat); ex = model_status();
            total++; if (rd !== ex) begin bad++; $display("FAIL tx_ovf_status%0d got=%h exp=%h", i, rd, ex); end
            $display("tx overflow: status=%h", rd);
        end
        tx_step(v, d);
        total++; if (v !== 1'b1 || d !== tx_m[0]) begin bad++; $display("FAIL tx_ovf_first got=%b/%h exp=1/%h", v, d, tx_m[0]); end
        void'(tx_m.pop_front());
        access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat); ex = model_status();
        total++; if (rd !== ex) begin bad++; $display("FAIL tx_ovf_status_after got=%h exp=%h", rd, ex); end
        while (tx_m.size() != 0) begin
            tx_step(v, d);
            total++; if (v !== 1'b1 || d !== tx_m[0]) begin bad++; $display("FAIL tx_ovf_drain got=%b/%h exp=1/%h", v, d, tx_m[0]); end
            void'(tx_m.pop_front());
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_ovf_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] rd, ex;
        logic [7:0]  d;
        logic        rdy;
        int lat;
        access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat); ex = model_rx_read();
        total++; if (rd !== ex) begin bad++; $display("FAIL rx_underflow_data got=%h exp=%h", rd, ex); end
        access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat); ex = model_status();
        total++; if (rd !== ex) begin bad++; $display("FAIL rx_underflow_status got=%h exp=%h", rd, ex); end
        $display("rx underflow: status=%h", rd);
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            rx_push_raw(d, rdy);
            total++; if (rdy !== (rx_m.size() < 16)) begin bad++; $display("FAIL rx_fill_ready%0d got=%b exp=%b", i, rdy, rx_m.size() < 16); end
            model_rx_push(d);
        end
        access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat); ex = model_status();
        total++; if (rd !== ex) begin bad++; $display("FAIL rx_drop_status got=%h exp=%h", rd, ex); end
        $display("rx drop: status=%h", rd);
        while (rx_m.size() != 0) begin
            access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat); ex = model_rx_read();
            total++; if (rd !== ex) begin bad++; $display("FAIL rx_drop_drain got=%h exp=%h", rd, ex); end
        end
    endtask

    task automatic test_read_write_collision();
        logic [31:0] rd, ex;
        logic        rdy;
        int lat;
        access(1'b1, 1'b1, 5'd4, 32'h0000_00EE, rd, lat);
        total++; if (rd !== 32'h0 || lat !== 1) begin bad++; $display("FAIL collision_tx got=%h/%0d exp=0/1", rd, lat); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL collision_no_push got=%b exp=0", tx_valid); end
        rx_push_raw(8'h5A, rdy);
        model_rx_push(8'h5A);
        access(1'b1, 1'b1, 5'd0, 32'h0000_0077, rd, lat); ex = model_rx_read();
        total++; if (rd !== ex) begin bad++; $display("FAIL collision_rx got=%h exp=%h", rd, ex); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL collision_rx_no_push got=%b exp=0", tx_valid); end
        $display("collision: rx data=%h", rd);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ex;
        logic        low;
        int lat;
        access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat); ex = model_rx_read();
        total++; if (rd !== ex) begin bad++; $display("FAIL b2b_setup got=%h exp=%h", rd, ex); end
        bus1.avs_address = 5'd8;
        bus1.avs_read    = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            low = (n % 2 == 1);
            ex  = low ? model_status() : 32'h0;
            total++; if (bus1.avs_waitrequest !== !low) begin bad++; $display("FAIL b2b_waitreq%0d got=%b exp=%b", n, bus1.avs_waitrequest, !low); end
            total++; if (bus1.avs_readdata !== ex) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", n, bus1.avs_readdata, ex); end
            $display("back-to-back: cycle=%0d waitreq=%b data=%h", n, bus1.avs_waitrequest, bus1.avs_readdata);
        end
        bus1.avs_read = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] rd, ex;
        logic [7:0]  d;
        logic        v, rdy;
        logic [4:0]  a;
        int lat, op;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: begin
                    access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat); ex = model_rx_read();
                    total++; if (rd !== ex || lat !== 1) begin bad++; $display("FAIL rnd_rx got=%h/%0d exp=%h/1", rd, lat, ex); end
                end
                1: begin
                    access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat); ex = model_status();
                    total++; if (rd !== ex || lat !== 1) begin bad++; $display("FAIL rnd_status got=%h/%0d exp=%h/1", rd, lat, ex); end
                end
                2: begin
                    do a = 5'($urandom); while (a == 5'd0 || a == 5'd4 || a == 5'd8);
                    access(1'b1, 1'b0, a, 32'h0, rd, lat);
                    total++; if (rd !== 32'h0 || lat !== 1) begin bad++; $display("FAIL rnd_other_read a=%0d got=%h/%0d exp=0/1", a, rd, lat); end
                end
                3, 4: begin
                    d = 8'($urandom);
                    access(1'b0, 1'b1, 5'd4, {24'($urandom), d}, rd, lat);
                    model_tx_write(d);
                    total++; if (lat !== 1) begin bad++; $display("FAIL rnd_tx_write got=%0d exp=1", lat); end
                end
                5: begin
                    do a = 5'($urandom); while (a == 5'd4);
                    access(1'b0, 1'b1, a, $urandom, rd, lat);
                    total++; if (lat !== 1) begin bad++; $display("FAIL rnd_other_write got=%0d exp=1", lat); end
                end
                6: begin
                    d = 8'($urandom);
                    rx_push_raw(d, rdy);
                    total++; if (rdy !== (rx_m.size() < 16)) begin bad++; $display("FAIL rnd_rx_ready got=%b exp=%b", rdy, rx_m.size() < 16); end
                    model_rx_push(d);
                end
                default: begin
                    tx_step(v, d);
                    total++; if (v !== (tx_m.size() != 0)) begin bad++; $display("FAIL rnd_tx_valid got=%b exp=%b", v, tx_m.size() != 0); end
                    if (tx_m.size() != 0) begin
                        total++; if (d !== tx_m[0]) begin bad++; $display("FAIL rnd_tx_data got=%h exp=%h", d, tx_m[0]); end
                        void'(tx_m.pop_front());
                    end
                end
            endcase
        end
        while (tx_m.size() != 0) begin
            tx_step(v, d);
            total++; if (v !== 1'b1 || d !== tx_m[0]) begin bad++; $display("FAIL rnd_tx_final got=%b/%h exp=1/%h", v, d, tx_m[0]); end
            void'(tx_m.pop_front());
        end
        while (rx_m.size() != 0) begin
            access(1'b1, 1'b0, 5'd0, 32'h0, rd, lat); ex = model_rx_read();
            total++; if (rd !== ex) begin bad++; $display("FAIL rnd_rx_final got=%h exp=%h", rd, ex); end
        end
        access(1'b1, 1'b0, 5'd8, 32'h0, rd, lat); ex = model_status();
        total++; if (rd !== ex) begin bad++; $display("FAIL rnd_status_final got=%h exp=%h", rd, ex); end
        $display("random: final status=%h", rd);
    endtask

    task automatic test_reset_mid_access();
        logic low;
        int   responses;
        rst2_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus2.avs_address = 5'd8;
        bus2.avs_read    = 1'b1;
        @(posedge clk); #1;
        total++; if (bus2.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL w3_wait_state got=%b exp=1", bus2.avs_waitrequest); end
        rst2_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++; if (bus2.avs_waitrequest !== 1'b1 || bus2.avs_readdata !== 32'h0) begin bad++; $display("FAIL w3_in_reset%0d got=%b/%h exp=1/0", i, bus2.avs_waitrequest, bus2.avs_readdata); end
        end
        rst2_n    = 1'b1;
        responses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            low = (k % 4 == 3);
            if (bus2.avs_waitrequest === 1'b0) responses++;
            total++; if (bus2.avs_waitrequest !== !low) begin bad++; $display("FAIL w3_waitreq%0d got=%b exp=%b", k, bus2.avs_waitrequest, !low); end
            total++; if (bus2.avs_readdata !== (low ? 32'h40 : 32'h0)) begin bad++; $display("FAIL w3_data%0d got=%h exp=%h", k, bus2.avs_readdata, low ? 32'h40 : 32'h0); end
        end
        bus2.avs_read = 1'b0;
        $display("wait3: responses=%0d in 12 cycles", responses);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        unf_m = 1'b0; ovf_m = 1'b0; drop_m = 1'b0;
        bus1.avs_address = '0; bus1.avs_read = 1'b0; bus1.avs_write = 1'b0; bus1.avs_writedata = '0;
        bus2.avs_address = '0; bus2.avs_read = 1'b0; bus2.avs_write = 1'b0; bus2.avs_writedata = '0;
        rx_valid = 1'b0; rx_data = 8'h0; tx_ready = 1'b0;
        rx_valid2 = 1'b0; rx_data2 = 8'h0; tx_ready2 = 1'b0;
        test_reset();
        test_rx_stream();
        test_tx_stream();
        test_tx_overflow();
        test_rx_errors();
        test_read_write_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
